// File: rtl/rf_seq_ctrl.sv
// Multi-cycle sequencer for one instruction at a time: accept, register-file read,
// ALU execute with bounded wait, then a single-cycle register write-back.
module rf_seq_ctrl #(
    parameter int ALU_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr_in,
    output logic        instr_ready,
    output logic [15:0] rf_instr,
    output logic        rf_regwrite,
    output logic [15:0] rf_writedata,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        busy,
    output logic        illegal_op,
    output logic        timeout_err,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [3:0] OP_TYPE_A = 4'hF;
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [7:0] TMO_LAST  = 8'(ALU_TIMEOUT);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_run;
    logic [7:0]  r_wait;
    logic [7:0]  w_wait_next;
    logic [15:0] r_instr;
    logic [15:0] r_wdata;
    logic [15:0] r_retired;
    logic        r_regwrite;
    logic        r_alu_start;
    logic        r_illegal;
    logic        r_timeout;

    logic        w_accept;
    logic        w_capture;
    logic        w_retire;
    logic        w_regwrite_next;
    logic        w_start_next;
    logic        w_illegal_next;
    logic        w_timeout_next;

    // r_run keeps ready low until the first edge after reset release
    assign instr_ready = r_run && (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign w_accept    = instr_ready && instr_valid;

    always_comb begin
        w_state_next    = r_state;
        w_wait_next     = r_wait;
        w_capture       = 1'b0;
        w_retire        = 1'b0;
        w_regwrite_next = 1'b0;
        w_start_next    = 1'b0;
        w_illegal_next  = 1'b0;
        w_timeout_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (instr_in[15:12] == OP_TYPE_A) begin
                        w_state_next = READ;
                    end else if (instr_in[15:12] != OP_NOP) begin
                        w_illegal_next = 1'b1;
                    end
                end
            end
            READ: begin
                w_state_next = EXEC;
                w_wait_next  = 8'd1;
                w_start_next = 1'b1;
            end
            EXEC: begin
                // r_wait holds the number of the current EXEC cycle; done wins on the last one
                if (alu_done) begin
                    w_capture       = 1'b1;
                    w_state_next    = WB;
                    w_regwrite_next = (r_instr[11:8] != 4'd0);
                end else if (r_wait == TMO_LAST) begin
                    w_state_next   = IDLE;
                    w_timeout_next = 1'b1;
                end else begin
                    w_wait_next = r_wait + 8'd1;
                end
            end
            WB: begin
                w_state_next = IDLE;
                w_retire     = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_run       <= 1'b0;
            r_wait      <= 8'd0;
            r_instr     <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_retired   <= 16'h0000;
            r_regwrite  <= 1'b0;
            r_alu_start <= 1'b0;
            r_illegal   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_run       <= 1'b1;
            r_wait      <= w_wait_next;
            r_regwrite  <= w_regwrite_next;
            r_alu_start <= w_start_next;
            r_illegal   <= w_illegal_next;
            r_timeout   <= w_timeout_next;
            if (w_accept) begin
                r_instr <= instr_in;
            end
            if (w_capture) begin
                r_wdata <= alu_result;
            end
            if (w_retire) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    assign rf_instr     = r_instr;
    assign rf_regwrite  = r_regwrite;
    assign rf_writedata = r_wdata;
    assign alu_start    = r_alu_start;
    assign illegal_op   = r_illegal;
    assign timeout_err  = r_timeout;
    assign retired      = r_retired;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Directed bench for rf_seq_ctrl: one instance with the default timeout and one
// with ALU_TIMEOUT=4, sharing stimulus; expected values are hand-computed.
module tb_rf_seq_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        instr_valid;
    logic [15:0] instr_in;
    logic        alu_done;
    logic [15:0] alu_result;

    logic        instr_ready, rf_regwrite, alu_start, busy, illegal_op, timeout_err;
    logic [15:0] rf_instr, rf_writedata, retired;
    logic        instr_ready_t, rf_regwrite_t, alu_start_t, busy_t, illegal_op_t, timeout_err_t;
    logic [15:0] rf_instr_t, rf_writedata_t, retired_t;

    rf_seq_ctrl dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_in(instr_in),
        .instr_ready(instr_ready), .rf_instr(rf_instr), .rf_regwrite(rf_regwrite),
        .rf_writedata(rf_writedata), .alu_start(alu_start), .alu_done(alu_done),
        .alu_result(alu_result), .busy(busy), .illegal_op(illegal_op),
        .timeout_err(timeout_err), .retired(retired)
    );

    rf_seq_ctrl #(.ALU_TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_in(instr_in),
        .instr_ready(instr_ready_t), .rf_instr(rf_instr_t), .rf_regwrite(rf_regwrite_t),
        .rf_writedata(rf_writedata_t), .alu_start(alu_start_t), .alu_done(alu_done),
        .alu_result(alu_result), .busy(busy_t), .illegal_op(illegal_op_t),
        .timeout_err(timeout_err_t), .retired(retired_t)
    );

    // Select which instance run_op observes
    logic        use_to = 1'b0;
    logic        w_ready, w_busy, w_start, w_wr, w_tmo, w_ill;
    logic [15:0] w_wd, w_instr;
    assign w_ready = use_to ? instr_ready_t : instr_ready;
    assign w_busy  = use_to ? busy_t        : busy;
    assign w_start = use_to ? alu_start_t   : alu_start;
    assign w_wr    = use_to ? rf_regwrite_t : rf_regwrite;
    assign w_tmo   = use_to ? timeout_err_t : timeout_err;
    assign w_ill   = use_to ? illegal_op_t  : illegal_op;
    assign w_wd    = use_to ? rf_writedata_t : rf_writedata;
    assign w_instr = use_to ? rf_instr_t    : rf_instr;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offers one instruction, plays an ALU with done in EXEC cycle lat (0 = never),
    // and records what the selected instance did until it returns to IDLE.
    task automatic run_op(input logic [15:0] ins, input int lat, input logic [15:0] res,
                          output int n_start, output int n_wr, output int wr_c,
                          output logic [15:0] wr_data, output logic [15:0] wr_ins,
                          output int n_tmo, output int tmo_c, output int n_ill, output int len);
        n_start = 0; n_wr = 0; wr_c = -1; wr_data = 16'h0; wr_ins = 16'h0;
        n_tmo = 0; tmo_c = -1; n_ill = 0; len = -1;
        check("ready_before_op", {31'd0, w_ready}, 32'd1);
        instr_valid = 1'b1;
        instr_in    = ins;
        alu_done    = 1'b0;
        alu_result  = res ^ 16'h5A5A;
        cyc();
        instr_valid = 1'b0;
        instr_in    = 16'h1111;
        for (int c = 1; c <= 40; c++) begin
            if (w_start) n_start++;
            if (w_wr) begin
                n_wr++; wr_c = c; wr_data = w_wd; wr_ins = w_instr;
            end
            if (w_tmo) begin
                n_tmo++; tmo_c = c;
            end
            if (w_ill) n_ill++;
            if (!w_busy) begin
                len = c;
                break;
            end
            alu_done   = (lat > 0) && (c == lat + 1);
            alu_result = alu_done ? res : (res ^ 16'h5A5A);
            cyc();
        end
        alu_done = 1'b0;
        $display("op %h lat=%0d: starts=%0d writes=%0d wr_cycle=%0d data=%h timeouts=%0d illegal=%0d len=%0d",
                 ins, lat, n_start, n_wr, wr_c, wr_data, n_tmo, n_ill, len);
    endtask

    int          ns, nw, wc, nt, tc, ni, ln;
    logic [15:0] wd, wi;
    logic [15:0] words [3];
    int          acc, wr_cnt, ill_cnt;
    int          acc_c [3];

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr_in    = 16'h0000;
        alu_done    = 1'b0;
        alu_result  = 16'h0000;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ctrl", {28'd0, rf_regwrite, alu_start, illegal_op, timeout_err}, 32'd0);
        check("rst_data", {rf_instr, rf_writedata}, 32'd0);
        check("rst_retired", {16'd0, retired}, 32'd0);
        check("rst_retired_t", {16'd0, retired_t}, 32'd0);
        repeat (3) cyc();
        check("rst_hold_ready", {31'd0, instr_ready}, 32'd0);
        reset = 1'b1;
        cyc();
        check("ready_after_rst", {31'd0, instr_ready}, 32'd1);

        // Type A with done tied high
        alu_done = 1'b1; alu_result = 16'hBEEF;
        instr_valid = 1'b1; instr_in = 16'hF123;
        cyc();
        instr_valid = 1'b0;
        check("c1_busy", {31'd0, busy}, 32'd1);
        check("c1_ready", {31'd0, instr_ready}, 32'd0);
        check("c1_start", {31'd0, alu_start}, 32'd0);
        check("c1_instr", {16'd0, rf_instr}, 32'h0000F123);
        cyc();
        check("c2_start", {31'd0, alu_start}, 32'd1);
        check("c2_wr", {31'd0, rf_regwrite}, 32'd0);
        cyc();
        check("c3_wr", {31'd0, rf_regwrite}, 32'd1);
        check("c3_start", {31'd0, alu_start}, 32'd0);
        check("c3_instr", {16'd0, rf_instr}, 32'h0000F123);
        check("c3_wdata", {16'd0, rf_writedata}, 32'h0000BEEF);
        cyc();
        check("c4_wr", {31'd0, rf_regwrite}, 32'd0);
        check("c4_retired", {16'd0, retired}, 32'd1);
        check("c4_ready", {31'd0, instr_ready}, 32'd1);
        alu_done = 1'b0;
        $display("op F123 immediate done: retired=%h", retired);

        // ALU latency 5
        run_op(16'hF2A7, 5, 16'h1234, ns, nw, wc, wd, wi, nt, tc, ni, ln);
        check("lat5_starts", ns, 1);
        check("lat5_writes", nw, 1);
        check("lat5_wr_cycle", wc, 7);
        check("lat5_wdata", {16'd0, wd}, 32'h00001234);
        check("lat5_winstr", {16'd0, wi}, 32'h0000F2A7);
        check("lat5_len", ln, 8);
        check("lat5_retired", {16'd0, retired}, 32'd2);

        // NOP
        run_op(16'h0000, 0, 16'h0000, ns, nw, wc, wd, wi, nt, tc, ni, ln);
        check("nop_pulses", ns + nw + nt + ni, 0);
        check("nop_len", ln, 1);
        check("nop_instr", {16'd0, rf_instr}, 32'h0);

        // Unsupported opcode
        run_op(16'h3456, 0, 16'h0000, ns, nw, wc, wd, wi, nt, tc, ni, ln);
        check("ill_pulse", ni, 1);
        check("ill_starts", ns, 0);
        check("ill_len", ln, 1);
        cyc();
        check("ill_one_cycle", {31'd0, illegal_op}, 32'd0);
        check("ill_wdata_kept", {16'd0, rf_writedata}, 32'h00001234);
        check("ill_retired", {16'd0, retired}, 32'd2);

        // rd = 0 retires without a write
        run_op(16'hF0AB, 2, 16'hAAAA, ns, nw, wc, wd, wi, nt, tc, ni, ln);
        check("r0_writes", nw, 0);
        check("r0_starts", ns, 1);
        check("r0_len", ln, 5);
        check("r0_retired", {16'd0, retired}, 32'd3);
        check("r0_wdata", {16'd0, rf_writedata}, 32'h0000AAAA);

        // Stream of three Type A ops across the retired counter wrap
        force dut.r_retired = 16'hFFFF;
        cyc();
        release dut.r_retired;
        words[0] = 16'hF111; words[1] = 16'hF222; words[2] = 16'hF333;
        acc = 0; wr_cnt = 0; ill_cnt = 0;
        alu_done = 1'b1; alu_result = 16'hC0DE;
        instr_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (rf_regwrite) wr_cnt++;
            if (illegal_op) ill_cnt++;
            if (instr_ready && acc < 3) begin
                acc_c[acc] = c;
                instr_in = words[acc];
                acc++;
            end else if (instr_ready) begin
                instr_valid = 1'b0;
            end else begin
                instr_in = 16'h3456;
            end
            cyc();
        end
        instr_valid = 1'b0; alu_done = 1'b0;
        $display("stream: accepts=%0d at %0d/%0d/%0d writes=%0d retired=%h",
                 acc, acc_c[0], acc_c[1], acc_c[2], wr_cnt, retired);
        check("stream_accepts", acc, 3);
        check("stream_gap1", acc_c[1] - acc_c[0], 4);
        check("stream_gap2", acc_c[2] - acc_c[1], 4);
        check("stream_writes", wr_cnt, 3);
        check("stream_no_illegal", ill_cnt, 0);
        check("stream_wrap", {16'd0, retired}, 32'h00000002);
        check("stream_last_instr", {16'd0, rf_instr}, 32'h0000F333);

        // Reset in the middle of EXEC
        instr_valid = 1'b1; instr_in = 16'hF456; alu_done = 1'b0;
        cyc();
        instr_valid = 1'b0;
        cyc();
        cyc();
        check("mid_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_ctrl", {26'd0, instr_ready, busy, rf_regwrite, alu_start, illegal_op, timeout_err}, 32'd0);
        check("mid_rst_data", {rf_instr, rf_writedata}, 32'd0);
        check("mid_rst_retired", {16'd0, retired}, 32'd0);
        alu_done = 1'b1; alu_result = 16'h9999;
        cyc();
        check("mid_rst_no_wr", {31'd0, rf_regwrite}, 32'd0);
        cyc();
        check("mid_rst_no_wr2", {15'd0, rf_regwrite, rf_writedata}, 32'd0);
        alu_done = 1'b0;
        reset = 1'b1;
        cyc();
        check("mid_ready_after", {31'd0, instr_ready}, 32'd1);

        // Timeout with ALU_TIMEOUT=4
        use_to = 1'b1;
        run_op(16'hF345, 0, 16'h4444, ns, nw, wc, wd, wi, nt, tc, ni, ln);
        check("tmo_pulse", nt, 1);
        check("tmo_cycle", tc, 6);
        check("tmo_len", ln, 6);
        check("tmo_writes", nw, 0);
        check("tmo_starts", ns, 1);
        check("tmo_retired", {16'd0, retired_t}, 32'd0);
        check("tmo_wdata_kept", {16'd0, rf_writedata_t}, 32'd0);
        cyc();
        check("tmo_one_cycle", {31'd0, timeout_err_t}, 32'd0);

        // Done in the last allowed EXEC cycle wins
        run_op(16'hF567, 4, 16'h7777, ns, nw, wc, wd, wi, nt, tc, ni, ln);
        check("tmo4_no_err", nt, 0);
        check("tmo4_writes", nw, 1);
        check("tmo4_wr_cycle", wc, 6);
        check("tmo4_wdata", {16'd0, wd}, 32'h00007777);
        check("tmo4_len", ln, 7);
        check("tmo4_retired", {16'd0, retired_t}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rf_seq_ctrl.md
# rf_seq_ctrl

Multi-cycle sequencer that drives the 16-bit register file and the ALU for one instruction at a time. Accepts an instruction over a valid/ready handshake, presents it to the register file for the operand read, starts the ALU, waits for its result, and then issues a single-cycle register write-back. Sits between instruction fetch and the register file/ALU pair, and owns the register file's `RegWrite`, `instruc_in` and `Writedata` inputs.

## Interface
- `ALU_TIMEOUT`, default 16: maximum EXEC cycles to wait for `alu_done` (legal range 1..255).
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `instr_valid` in 1: an instruction is offered on `instr_in`.
- `instr_in` in 16: instruction word; [15:12] opcode, [11:8] rd/rs1, [7:4] rs2, [3:0] funct.
- `instr_ready` out 1: controller can accept an instruction.
- `rf_instr` out 16: instruction word driven to the register file.
- `rf_regwrite` out 1: register file write enable.
- `rf_writedata` out 16: register file write data.
- `alu_start` out 1: single-cycle ALU start pulse.
- `alu_done` in 1: ALU result valid on `alu_result`.
- `alu_result` in 16: ALU result.
- `busy` out 1: high in every state except IDLE.
- `illegal_op` out 1: one-cycle pulse when an unsupported opcode is dropped.
- `timeout_err` out 1: one-cycle pulse when an ALU timeout aborts an instruction.
- `retired` out 16: count of written-back instructions; wraps FFFF->0000.

## Operation
- States: IDLE, READ, EXEC, WB.
- IDLE: `instr_ready`=1. Handshake occurs when `instr_valid && instr_ready` at a rising edge; the word is captured into `rf_instr`.
  - Opcode 4'b1111 (Type A): go to READ.
  - Opcode 4'b0000 (NOP): stay in IDLE. No other effect.
  - Any other opcode: stay in IDLE and pulse `illegal_op` in the next cycle.
- READ: one cycle. `rf_instr` is held so the register file latches op1/op2 on this edge. Next state is EXEC.
- EXEC:
  - `alu_start`=1 in the first EXEC cycle only.
  - The wait counter clears on entry and increments each EXEC cycle.
  - `alu_done`=1: capture `alu_result` into `rf_writedata` and go to WB.
  - `alu_done` is sampled from the first EXEC cycle, so a same-cycle done is legal.
- Timeout: if EXEC cycle number `ALU_TIMEOUT` ends without `alu_done`, go to IDLE, pulse `timeout_err` in the first IDLE cycle, and skip the write-back. If `alu_done` arrives in that last cycle, it wins.
- WB: `rf_regwrite`=1 for exactly one cycle, with `rf_instr` and `rf_writedata` held stable.
  - If rd (`rf_instr[11:8]`) = 0, `rf_regwrite` stays 0 (R0 is never written), but the instruction still retires.
  - `retired` increments at the end of WB. Next state is IDLE.
- `alu_done` is ignored outside EXEC.
- `instr_valid` outside IDLE is ignored; the producer must hold the word until it sees ready.
- `rf_instr` changes only on an accepted handshake. `rf_writedata` changes only on an EXEC capture.

## Timing
- Reset values while `reset`=0:
  - State IDLE.
  - `instr_ready`=0, `rf_instr`=16'h0000, `rf_regwrite`=0, `rf_writedata`=16'h0000, `alu_start`=0.
  - `busy`=0, `illegal_op`=0, `timeout_err`=0, `retired`=16'h0000.
- `instr_ready` rises in the first cycle after reset deasserts.
- Reset mid-operation (any state) aborts immediately: no write-back, no pulse, captured instruction lost.
- Minimum latency with `alu_done` in the first EXEC cycle:
  - Accept at edge E0.
  - READ cycle E0->E1.
  - EXEC with `alu_start` E1->E2.
  - WB with `rf_regwrite` E2->E3; the register file writes at E3.
  - `instr_ready`=1 from E3; next accept at E4.
- Back-to-back Type A throughput is one instruction per 4 cycles.
- Each extra ALU cycle adds one cycle.
- Timeout path: accept to `timeout_err` pulse is 1 + `ALU_TIMEOUT` + 1 cycles.
- All outputs are registered. `instr_ready` and `busy` are decoded from the state register only.

## Test plan
- Reset sequencing:
  - Assert reset mid-EXEC -> all outputs at reset values asynchronously, no `rf_regwrite`.
  - Release reset -> `instr_ready`=1 the next cycle.
- Type A, immediate done: offer 16'hF123 with `alu_done` tied high and `alu_result`=16'hBEEF.
  - Required: `alu_start` in cycle 2.
  - Required: `rf_regwrite`=1 for one cycle in cycle 3 with `rf_instr`=16'hF123 and `rf_writedata`=16'hBEEF.
  - Required: `retired`=1.
- ALU latency 5: `alu_done` in EXEC cycle 5 -> WB follows in the next cycle, `alu_start` high exactly once, `rf_writedata` equals the result sampled with done.
- Timeout with `ALU_TIMEOUT`=4 and no done:
  - Required: `timeout_err` pulses once 6 cycles after accept, no `rf_regwrite`, `retired` unchanged.
  - Variant with done in EXEC cycle 4: write-back happens and no error.
- Opcode filtering:
  - 16'h0000 -> no pulses, stays IDLE.
  - 16'h3456 -> `illegal_op` for one cycle, no `alu_start`.
  - 16'hF0AB (rd=0) -> retires with `rf_regwrite` never high.
- Stream and wrap: preload `retired`=16'hFFFF via 65535 NOPs-free Type A ops, or a force in sim; then run 3 back-to-back Type A ops with `instr_valid` held high.
  - Required: accepts every 4 cycles.
  - Required: `retired` wraps to 16'h0002.
  - Required: `instr_valid` during busy is ignored.
